// File: rtl/frame_stream_source.sv
// Frame reader: walks a frame buffer in raster order and emits a gap-free tagged
// pixel stream for filter_unit, followed by flush words that drain the filter.
module frame_stream_source #(
    parameter int                   TAG_WIDTH    = 2,
    parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0,
    parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1,
    parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2,
    parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3,
    parameter int                   OPE_WIDTH    = 3,
    parameter int                   ADDR_WIDTH   = 20,
    parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           image_width,
    input  logic [31:0]           image_height,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  reflesh,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    // Handshake: none. start is a level request sampled only in IDLE; the
    // stream has no ready, every cycle from first pixel to last flush word is valid.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [31:0]             width_q;
    logic [31:0]             height_q;
    logic [31:0]             col_q;
    logic [31:0]             row_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             flush_len_q;
    logic [31:0]             flush_cnt_q;
    logic                    v1_q;
    logic [TAG_WIDTH-1:0]    tag1_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    reflesh_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    last_col_d;
    logic                    last_pix_d;
    logic [TAG_WIDTH-1:0]    tag_d;
    logic [31:0]             flush_len_d;
    logic [DATA_WIDTH-1:0]   word_d;

    always_comb begin
        last_col_d  = (col_q == width_q - 32'd1);
        last_pix_d  = last_col_d && (row_q == height_q - 32'd1);
        // The end tag wins over row parity, also for a 1x1 frame.
        if (last_pix_d)
            tag_d = DATA_END_TAG;
        else if (row_q[0])
            tag_d = DATA_TAG1;
        else
            tag_d = DATA_TAG0;
        flush_len_d = 32'(OPE_WIDTH - 1) * image_width + 32'(OPE_WIDTH);
        word_d      = v1_q ? {tag1_q, mem_rdata} : {INVALID_TAG, 8'h00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            flush_len_q <= '0;
            flush_cnt_q <= '0;
            v1_q        <= 1'b0;
            tag1_q      <= '0;
            data_q      <= '0;
            reflesh_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Tag travels one stage alongside the BRAM read, then joins the pixel.
            v1_q      <= (state_q == STREAM);
            tag1_q    <= tag_d;
            data_q    <= word_d;
            reflesh_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (image_width != 32'd0) && (image_height != 32'd0)) begin
                        width_q     <= image_width;
                        height_q    <= image_height;
                        flush_len_q <= flush_len_d;
                        reflesh_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    addr_q      <= '0;
                    col_q       <= '0;
                    row_q       <= '0;
                    flush_cnt_q <= '0;
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (last_pix_d) begin
                        state_q <= FLUSH;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (last_col_d) begin
                            col_q <= '0;
                            row_q <= row_q + 32'd1;
                        end else begin
                            col_q <= col_q + 32'd1;
                        end
                    end
                end
                FLUSH: begin
                    // The first two FLUSH cycles still drain pixels, hence done at count F+1.
                    if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 32'd1;
                        if (flush_cnt_q == flush_len_q)
                            done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign reflesh   = reflesh_q;
    assign data_out  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: two instances (OPE_WIDTH 3 and 5) with a
// registered frame-buffer model, a table of frame sizes and corner-case sequences.
module tb_frame_stream_source;

    localparam int AW = 20;
    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          sel;
    logic [31:0]   image_width;
    logic [31:0]   image_height;
    logic [7:0]    pat;

    logic [AW-1:0] addr3, addr5;
    logic [7:0]    rdata3, rdata5;
    logic          refl3, refl5, busy3, busy5, done3, done5;
    logic [DW-1:0] dout3, dout5;
    logic [1:0]    st3, st5;
    logic          start3, start5;

    assign start3 = start & ~sel;
    assign start5 = start & sel;

    frame_stream_source #(.OPE_WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .image_width(image_width), .image_height(image_height),
        .mem_addr(addr3), .mem_rdata(rdata3), .reflesh(refl3),
        .data_out(dout3), .busy(busy3), .done(done3), .dbg_state(st3)
    );

    frame_stream_source #(.OPE_WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5),
        .image_width(image_width), .image_height(image_height),
        .mem_addr(addr5), .mem_rdata(rdata5), .reflesh(refl5),
        .data_out(dout5), .busy(busy5), .done(done5), .dbg_state(st5)
    );

    // Synchronous frame buffer: contents are addr[7:0] ^ pat.
    always @(posedge clk) begin
        rdata3 <= addr3[7:0] ^ pat;
        rdata5 <= addr5[7:0] ^ pat;
    end

    logic [AW-1:0] obs_addr;
    logic          obs_refl, obs_busy, obs_done;
    logic [DW-1:0] obs_dout;
    logic [1:0]    obs_st;
    always_comb begin
        obs_addr = sel ? addr5 : addr3;
        obs_refl = sel ? refl5 : refl3;
        obs_busy = sel ? busy5 : busy3;
        obs_done = sel ? done5 : done3;
        obs_dout = sel ? dout5 : dout3;
        obs_st   = sel ? st5   : st3;
    end

    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int w;
        int h;
        int f;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [31:0] a);
        return a[7:0] ^ pat;
    endfunction

    // Entered at a negedge in IDLE with start=1 already applied; returns at the
    // negedge of the idle cycle that follows done.
    task automatic expect_frame(input int w, input int h, input int f, input bit hold, input int poke);
        int n;
        logic [1:0] tag;
        logic [DW-1:0] e;
        n = w * h;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == h - 1 && c == w - 1) tag = 2'd3;
                else if (r % 2 == 1)          tag = 2'd2;
                else                          tag = 2'd1;
                exp_q.push_back({tag, mem_val(r * w + c)});
            end
        end
        for (int i = 0; i < f; i++) exp_q.push_back('0);

        @(negedge clk);
        if (!hold) start = 1'b0;
        check("clear_reflesh", obs_refl, 1);
        check("clear_busy", obs_busy, 1);
        check("clear_dout", obs_dout, 0);
        check("clear_done", obs_done, 0);

        for (int cyc = 0; cyc < n + f + 2; cyc++) begin
            @(negedge clk);
            if (cyc == poke) begin
                start        = 1'b1;
                image_width  = $urandom_range(0, 9);
                image_height = $urandom_range(0, 9);
            end else if (!hold) begin
                start = 1'b0;
            end
            check("stream_busy", obs_busy, 1);
            check("stream_reflesh", obs_refl, 0);
            check("mem_addr", obs_addr, (cyc < n) ? cyc : n - 1);
            if (cyc < 2) begin
                check("pre_dout", obs_dout, 0);
                check("pre_done", obs_done, 0);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got an extra word 0x%0h expected none", obs_dout);
            end else begin
                e = exp_q.pop_front();
                check("data_out", obs_dout, e);
                check("done", obs_done, exp_q.size() == 0);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d words left expected 0", exp_q.size());
        end
        exp_q.delete();

        @(negedge clk);
        if (!hold) start = 1'b0;
        check("post_busy", obs_busy, 0);
        check("post_done", obs_done, 0);
        check("post_dout", obs_dout, 0);
        check("post_reflesh", obs_refl, 0);
        check("post_state", obs_st, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vecs[0] = '{4, 3, 11};
        vecs[1] = '{1, 1, 5};
        vecs[2] = '{5, 2, 13};
        vecs[3] = '{2, 5, 7};
        vecs[4] = '{7, 1, 17};

        rst = 1'b1; start = 1'b0; sel = 1'b0; pat = 8'h00;
        image_width = 0; image_height = 0;
        repeat (2) @(negedge clk);
        check("rst_addr", obs_addr, 0);
        check("rst_refl", obs_refl, 0);
        check("rst_dout", obs_dout, 0);
        check("rst_busy", obs_busy, 0);
        check("rst_done", obs_done, 0);
        check("rst_state", obs_st, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dout", obs_dout, 0);
        check("idle_busy", obs_busy, 0);

        // Frame-size table; entry 2 also pulses start mid-stream.
        for (int i = 0; i < 5; i++) begin
            pat          = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            image_width  = vecs[i].w;
            image_height = vecs[i].h;
            start        = 1'b1;
            expect_frame(vecs[i].w, vecs[i].h, vecs[i].f, 1'b0, (i == 2) ? 3 : -1);
        end

        // Zero-sized requests are ignored.
        for (int k = 0; k < 2; k++) begin
            image_width  = (k == 0) ? 0 : 4;
            image_height = (k == 0) ? 3 : 0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("zero_reflesh", obs_refl, 0);
            check("zero_busy", obs_busy, 0);
            repeat (3) begin
                @(negedge clk);
                check("zero_busy_hold", obs_busy, 0);
                check("zero_state", obs_st, 0);
            end
        end

        // Asynchronous reset while pixel 6 is being addressed.
        pat = 8'($urandom_range(0, 255));
        image_width = 4; image_height = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            check("abort_no_done", obs_done, 0);
            if (obs_addr == 6) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_wait: got no address 6 expected it within 20 cycles");
        end
        #2 rst = 1'b1;
        #1;
        check("abort_addr", obs_addr, 0);
        check("abort_dout", obs_dout, 0);
        check("abort_busy", obs_busy, 0);
        check("abort_done", obs_done, 0);
        check("abort_state", obs_st, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_after_done", obs_done, 0);
        check("abort_after_busy", obs_busy, 0);
        image_width = 4; image_height = 3; start = 1'b1;
        expect_frame(4, 3, 11, 1'b0, -1);

        // start held high: frames repeat, reflesh two cycles after done.
        pat = 8'($urandom_range(0, 255));
        image_width = 3; image_height = 2; start = 1'b1;
        for (int k = 0; k < 3; k++) expect_frame(3, 2, 9, 1'b1, -1);
        start = 1'b0;
        @(negedge clk);
        check("hold_release_busy", obs_busy, 0);

        // Wider window on the second instance.
        sel = 1'b1;
        pat = 8'($urandom_range(0, 255));
        image_width = 8; image_height = 4; start = 1'b1;
        expect_frame(8, 4, 37, 1'b0, -1);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
Frame reader and stream transmitter feeding the filter pipeline. On start, it reads one 8-bit image frame from a synchronous BlockRAM frame buffer in raster order and emits the tagged pixel stream that filter_unit consumes: one word per clock, no bubbles. Rows alternate DATA_TAG0 and DATA_TAG1, and the last pixel is tagged DATA_END_TAG. After the frame it appends invalid flush words so the filter's line buffers and operation pipeline drain, then signals done. It also drives the filter's reflesh so each frame starts from cleared filter state.

Parameters:
TAG_WIDTH, 2, width of the tag field
INVALID_TAG, 2'd0, tag for non-pixel / flush words
DATA_TAG0, 2'd1, tag for pixels on even rows (row 0, 2, ...)
DATA_TAG1, 2'd2, tag for pixels on odd rows
DATA_END_TAG, 2'd3, tag for the final pixel of the frame
OPE_WIDTH, 3, filter window size; sets the flush length
ADDR_WIDTH, 20, frame-buffer address width
DATA_WIDTH, 8+TAG_WIDTH, output word width, formatted as {tag, pixel[7:0]}

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous reset, active-high
start  in  1  frame request; sampled only in IDLE
image_width  in  32  pixels per row; latched at accepted start
image_height  in  32  rows per frame; latched at accepted start
mem_addr  out  ADDR_WIDTH  registered frame-buffer read address
mem_rdata  in  8  read data; valid the cycle after mem_addr is presented
reflesh  out  1  one-cycle clear pulse to the filter
data_out  out  DATA_WIDTH  tagged stream word {tag, pixel}
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse when the last flush word is on data_out

Behaviour:
- Reset (async, immediate): state=IDLE; mem_addr=0, reflesh=0, data_out=0 (INVALID_TAG, pixel 0), busy=0, done=0; all counters=0. Reset mid-frame aborts the frame with no done pulse.
- IDLE:
  - data_out=0.
  - start=1 with image_width!=0 and image_height!=0: latch W and H, go to CLEAR.
  - start with W=0 or H=0 is ignored; the block stays IDLE.
- CLEAR (1 cycle): reflesh=1, data_out invalid, busy=1, then go to STREAM.
- STREAM:
  - mem_addr steps 0,1,...,W*H-1, one per cycle, with no gaps.
  - Column counter wraps at W-1 and increments the row counter. Address counter is ADDR_WIDTH bits; W*H > 2^ADDR_WIDTH is unsupported and the address wraps modulo.
  - Tag is computed from the row/column of the issued address and delayed alongside it:
    - row even -> DATA_TAG0;
    - row odd -> DATA_TAG1;
    - (row=H-1, col=W-1) -> DATA_END_TAG. The end tag overrides, including when W=H=1.
  - Pipeline timing: address n at cycle k; mem_rdata at k+1; data_out={tag_n, mem_rdata} registered, visible at k+2.
  - Fixed latency: 2 cycles from mem_addr to data_out.
  - After issuing the last address, go to FLUSH.
- FLUSH:
  - data_out continues contiguously after the END word with F=(OPE_WIDTH-1)*W+OPE_WIDTH words of {INVALID_TAG, 8'h00}. The flush counter is 32-bit.
  - mem_addr holds its last value.
  - done=1 in the cycle the F-th flush word is on data_out.
  - Next cycle: state=IDLE, busy=0, data_out=0.
- done coincides with the last FLUSH cycle. The first IDLE cycle after done may accept a new start, giving back-to-back frames separated by exactly one idle word plus the CLEAR cycle.
- start while busy is ignored. image_width/height changes while busy have no effect.
- The stream never stalls. Every cycle from the first pixel word to the last flush word carries a defined word.

Test Plan:
- W=4, H=3, OPE_WIDTH=3, frame buffer = addr value:
  - start -> reflesh pulse 1 cycle later; mem_addr 0..11 on consecutive cycles;
  - data_out tags 1,1,1,1,2,2,2,2,1,1,1,3 with pixels 0..11, each 2 cycles after its address;
  - then 11 words of 0x000; done on the 11th; busy then drops.
- W=1, H=1 -> single word {3, mem[0]}, then 3*... F=(2)*1+3=5 invalid words, then done.
- W=5, H=2; start pulsed again mid-STREAM and with W=0 in IDLE -> exactly one frame emitted; the W=0 start produces no reflesh and no busy.
- rst asserted asynchronously at pixel 6 of a 4x3 frame -> outputs zero immediately with no done pulse; a following start produces a complete, correct frame.
- start held high continuously, W=3, H=2 -> frames repeat; each new reflesh occurs exactly 2 cycles after the previous done.
- OPE_WIDTH=5, W=8, H=4 -> flush length 4*8+5=37 invalid words; row tags alternate per 8 pixels; last pixel tag 3.
